// File: rtl/input_mem_sequencer.sv
// Sequencer for the single-port input value memory: loads one frame of bin values,
// then scans it out in address order with the neuron index attached.
module input_mem_sequencer #(
    parameter int INPUT_NEURON_NUM = 1023,
    parameter int ADDR_W           = 10,
    parameter int DATA_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              scan_start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              loaded,
    output logic              busy,
    output logic              scan_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOADED,
        SCAN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(INPUT_NEURON_NUM - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
    logic [ADDR_W-1:0] index_d;
    logic              rd_pending, rd_pending_d;
    logic              valid_d, loaded_d, done_d;
    logic              accept, issue, out_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            loaded     <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state      <= state_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            rd_pending <= rd_pending_d;
            out_valid  <= valid_d;
            out_index  <= index_d;
            loaded     <= loaded_d;
            scan_done  <= done_d;
        end
    end

    always_comb begin
        accept  = (state == LOAD) && in_valid;
        issue   = (state == SCAN) && rd_pending && (!out_valid || out_ready);
        out_acc = out_valid && out_ready;

        in_ready    = (state == LOAD);
        busy        = (state == LOAD) || (state == SCAN);
        mem_wr_en   = accept;
        mem_addr_in = accept ? wr_ptr : '0;
        mem_data_in = accept ? in_data : '0;
        // A stalled output re-reads its own address so the registered read data stays put.
        mem_addr_out = (state == SCAN) ? (issue ? rd_ptr : out_index) : '0;
        out_data     = out_valid ? mem_data_out : '0;

        state_d      = state;
        wr_ptr_d     = wr_ptr;
        rd_ptr_d     = rd_ptr;
        rd_pending_d = rd_pending;
        valid_d      = out_valid;
        index_d      = out_index;
        loaded_d     = loaded;
        done_d       = 1'b0;

        if (abort) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            rd_pending_d = 1'b0;
            valid_d      = 1'b0;
            index_d      = '0;
            loaded_d     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state_d  = LOAD;
                        wr_ptr_d = '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (wr_ptr == LAST) begin
                            state_d  = LOADED;
                            loaded_d = 1'b1;
                            wr_ptr_d = '0;
                        end else begin
                            wr_ptr_d = wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                LOADED: begin
                    if (load_start) begin
                        state_d  = LOAD;
                        loaded_d = 1'b0;
                        wr_ptr_d = '0;
                    end else if (scan_start) begin
                        state_d      = SCAN;
                        rd_ptr_d     = '0;
                        rd_pending_d = 1'b1;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        valid_d = 1'b1;
                        index_d = rd_ptr;
                        if (rd_ptr == LAST) begin
                            rd_pending_d = 1'b0;
                        end else begin
                            rd_ptr_d = rd_ptr + ADDR_W'(1);
                        end
                    end else if (out_acc) begin
                        // Only the final index can be accepted without a follow-on issue.
                        valid_d = 1'b0;
                        if (out_index == LAST) begin
                            done_d   = 1'b1;
                            state_d  = LOADED;
                            rd_ptr_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_mem_sequencer.sv
// Directed/randomized bench for input_mem_sequencer with an external memory model and a
// frame queue as the reference for scan order and data.
module tb_input_mem_sequencer;

    localparam int N  = 1023;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, scan_start, abort;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr_in;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_data_out = '0;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          loaded, busy, scan_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] frame_q[$];

    always #5 clk = ~clk;

    // Single-port memory: registered read, read data frozen during writes.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr_in] <= mem_data_in;
        else           mem_data_out     <= mem[mem_addr_out];
    end

    input_mem_sequencer #(
        .INPUT_NEURON_NUM(N),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .scan_start(scan_start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .loaded(loaded), .busy(busy), .scan_done(scan_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_in_ready"},     in_ready,     0);
        check({pfx, "_mem_wr_en"},    mem_wr_en,    0);
        check({pfx, "_mem_addr_in"},  mem_addr_in,  0);
        check({pfx, "_mem_data_in"},  mem_data_in,  0);
        check({pfx, "_mem_addr_out"}, mem_addr_out, 0);
        check({pfx, "_out_valid"},    out_valid,    0);
        check({pfx, "_out_index"},    out_index,    0);
        check({pfx, "_out_data"},     out_data,     0);
        check({pfx, "_loaded"},       loaded,       0);
        check({pfx, "_busy"},         busy,         0);
        check({pfx, "_scan_done"},    scan_done,    0);
    endtask

    task automatic load_run(input bit both, input int gap_pct, input bit ramp);
        int cnt;
        load_start = 1'b1;
        scan_start = both;
        next_cycle();
        load_start = 1'b0;
        scan_start = 1'b0;
        frame_q.delete();
        @(negedge clk);
        check("load_in_ready", in_ready, 1);
        check("load_loaded_clr", loaded, 0);
        check("load_busy", busy, 1);
        next_cycle();
        cnt = 0;
        for (int cyc = 0; cyc < 8 * N && cnt < N; cyc++) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = ramp ? 8'(cnt) : 8'($urandom);
            @(negedge clk);
            check("load_wr_en", mem_wr_en, in_valid);
            if (in_valid) begin
                check("load_addr", mem_addr_in, cnt);
                check("load_data", mem_data_in, in_data);
                check("load_loaded_early", loaded, 0);
                frame_q.push_back(in_data);
                cnt++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        check("load_count", cnt, N);
        @(negedge clk);
        check("load_loaded_set", loaded, 1);
        check("load_in_ready_off", in_ready, 0);
        check("load_busy_off", busy, 0);
        check("load_wr_en_off", mem_wr_en, 0);
        next_cycle();
    endtask

    task automatic scan_run(input int ready_pct, input int abort_at);
        int            exp_idx;
        bit            done_seen;
        bit            held;
        logic [AW-1:0] h_idx;
        logic [DW-1:0] h_data;
        scan_start = 1'b1;
        out_ready  = 1'b0;
        next_cycle();
        scan_start = 1'b0;
        @(negedge clk);
        check("scan_entry_valid", out_valid, 0);
        check("scan_entry_busy", busy, 1);
        next_cycle();
        exp_idx   = 0;
        done_seen = 1'b0;
        held      = 1'b0;
        for (int cyc = 0; cyc < 6 * N && !done_seen; cyc++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            check("scan_wr_en", mem_wr_en, 0);
            if (scan_done) begin
                check("scan_done_count", exp_idx, N);
                check("scan_done_valid", out_valid, 0);
                check("scan_done_loaded", loaded, 1);
                done_seen = 1'b1;
            end else begin
                check("scan_valid", out_valid, 1);
                if (held) begin
                    check("scan_hold_idx", out_index, h_idx);
                    check("scan_hold_data", out_data, h_data);
                end
                check("scan_idx", out_index, exp_idx);
                if (exp_idx < N) check("scan_data", out_data, frame_q[exp_idx]);
                else             check("scan_overrun", exp_idx, N - 1);
                if (abort_at >= 0 && exp_idx == abort_at) begin
                    abort = 1'b1;
                    next_cycle();
                    abort = 1'b0;
                    out_ready = 1'b0;
                    @(negedge clk);
                    check_zero("abort");
                    next_cycle();
                    return;
                end
                held   = !out_ready;
                h_idx  = out_index;
                h_data = out_data;
                if (out_ready) exp_idx++;
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check("scan_finished", done_seen, 1);
        @(negedge clk);
        check("scan_done_single", scan_done, 0);
        check("scan_loaded_kept", loaded, 1);
        check("scan_busy_off", busy, 0);
        next_cycle();
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        scan_start = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        scan_start = 1'b1;
        next_cycle();
        scan_start = 1'b0;
        @(negedge clk);
        check_zero("idle_scan");
        next_cycle();

        load_run(1'b0, 0, 1'b1);
        scan_run(100, -1);
        scan_run(50, -1);

        load_run(1'b1, 30, 1'b0);
        scan_run(50, -1);
        scan_run(100, 500);

        scan_start = 1'b1;
        next_cycle();
        scan_start = 1'b0;
        @(negedge clk);
        check_zero("idle_scan_after_abort");
        next_cycle();

        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        repeat (100) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        next_cycle();

        load_run(1'b0, 10, 1'b1);
        scan_run(70, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
